// File: rtl/pulpemu_cam_gen.sv
// Synthetic parallel-camera source: divided pixel clock, vsync/hsync framing and
// selectable test patterns, all outputs registered and updated on the pclk falling edge.
module pulpemu_cam_gen #(
  parameter int PCLK_DIV = 2,
  parameter int WIDTH    = 16,
  parameter int HEIGHT   = 8,
  parameter int HBLANK   = 4,
  parameter int VBLANK   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [1:0]  mode_i,
  output logic        cam_pclk_o,
  output logic        cam_vsync_o,
  output logic        cam_hsync_o,
  output logic [7:0]  cam_data_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o
);

  localparam int              DW       = $clog2(PCLK_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(PCLK_DIV - 1);
  localparam logic [DW-1:0]   DIV_HALF = DW'(PCLK_DIV / 2);
  localparam logic [31:0]     VS_LAST  = 32'(VBLANK * (WIDTH + HBLANK) - 1);
  localparam logic [31:0]     HB_LAST  = 32'(HBLANK - 1);
  localparam logic [11:0]     X_LAST   = 12'(WIDTH - 1);
  localparam logic [11:0]     Y_LAST   = 12'(HEIGHT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_VS   = 2'd1;
  localparam logic [1:0] S_LINE = 2'd2;
  localparam logic [1:0] S_HBL  = 2'd3;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [11:0]   x_q, x_d, y_q, y_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    base_q, base_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          pclk_q, pclk_d;
  logic          vsync_q, vsync_d;
  logic          hsync_q, hsync_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick;
  logic          start;

  function automatic logic [7:0] pattern(input logic [1:0] m, input logic [7:0] x,
                                         input logic [7:0] y, input logic [7:0] base);
    case (m)
      2'd0:    pattern = x;
      2'd1:    pattern = x + y;
      2'd2:    pattern = base;
      default: pattern = (x[2] ^ y[2]) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // tick marks the last clk of a slot; everything registered below lands as div wraps to 0
  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    base_d  = base_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    start   = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: start = en_i;
        S_VS: begin
          if (cnt_q == VS_LAST) begin
            state_d = S_LINE;
            x_d     = '0;
            y_d     = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_LINE: begin
          if (x_q == X_LAST) begin
            state_d = S_HBL;
            cnt_d   = '0;
          end else begin
            x_d = x_q + 12'd1;
          end
        end
        default: begin
          if (cnt_q != HB_LAST) begin
            cnt_d = cnt_q + 32'd1;
          end else if (y_q != Y_LAST) begin
            state_d = S_LINE;
            x_d     = '0;
            y_d     = y_q + 12'd1;
          end else begin
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
            state_d = S_IDLE;
            start   = en_i;
          end
        end
      endcase
    end
    // A new frame snapshots the already-incremented count so pattern 2 shows frames completed so far
    if (start) begin
      state_d = S_VS;
      cnt_d   = '0;
      x_d     = '0;
      y_d     = '0;
      mode_d  = mode_i;
      base_d  = fcnt_d[7:0];
    end
  end

  always_comb begin
    pclk_d  = (div_d >= DIV_HALF);
    vsync_d = vsync_q;
    hsync_d = hsync_q;
    data_d  = data_q;
    busy_d  = busy_q;
    if (tick) begin
      vsync_d = (state_d == S_VS);
      hsync_d = (state_d == S_LINE);
      data_d  = (state_d == S_LINE) ? pattern(mode_d, x_d[7:0], y_d[7:0], base_d) : 8'h00;
      busy_d  = (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= '0;
      base_q  <= '0;
      fcnt_q  <= '0;
      pclk_q  <= 1'b0;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      fcnt_q  <= fcnt_d;
      pclk_q  <= pclk_d;
      vsync_q <= vsync_d;
      hsync_q <= hsync_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cam_pclk_o   = pclk_q;
  assign cam_vsync_o  = vsync_q;
  assign cam_hsync_o  = hsync_q;
  assign cam_data_o   = data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign frame_cnt_o  = fcnt_q;

endmodule

// File: tb/tb_pulpemu_cam_gen.sv
// Scoreboard bench for pulpemu_cam_gen: stimulus queues expected per-slot outputs of each
// frame, a monitor pops them on every pclk rise while busy; a PCLK_DIV=4 copy checks timing.
module tb_pulpemu_cam_gen;

  localparam int PD        = 2;
  localparam int W         = 16;
  localparam int H         = 8;
  localparam int HB        = 4;
  localparam int VB        = 2;
  localparam int LINE_CYC  = PD * (W + HB);
  localparam int FRAME_CYC = LINE_CYC * (VB + H);
  localparam int LINE2_CYC = LINE_CYC * (VB + 2) + 4 * PD;
  localparam int NF        = 8;

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic [7:0] d;
  } slot_t;

  logic        clk;
  logic        rst_i, en_i;
  logic [1:0]  mode_i;
  logic        cam_pclk_o, cam_vsync_o, cam_hsync_o, busy_o, frame_done_o;
  logic [7:0]  cam_data_o;
  logic [15:0] frame_cnt_o;

  logic        rst4, en4;
  logic [1:0]  mode4;
  logic        pclk4, vsync4, hsync4, busy4, done4;
  logic [7:0]  data4;
  logic [15:0] fcnt4;
  logic        fin4;

  slot_t       exp_q[$];
  logic [15:0] done_q[$];
  int          mcnt;
  int          checks;
  int          errors;
  int          cyc;
  logic        pclk_prev;

  pulpemu_cam_gen #(.PCLK_DIV(PD), .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VBLANK(VB)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i),
    .cam_pclk_o(cam_pclk_o), .cam_vsync_o(cam_vsync_o), .cam_hsync_o(cam_hsync_o),
    .cam_data_o(cam_data_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .frame_cnt_o(frame_cnt_o)
  );

  pulpemu_cam_gen #(.PCLK_DIV(4), .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VBLANK(VB)) u_dut4 (
    .clk_i(clk), .rst_i(rst4), .en_i(en4), .mode_i(mode4),
    .cam_pclk_o(pclk4), .cam_vsync_o(vsync4), .cam_hsync_o(hsync4),
    .cam_data_o(data4), .busy_o(busy4), .frame_done_o(done4), .frame_cnt_o(fcnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_pix(input int m, input int x, input int y, input int base);
    case (m)
      0:       return 8'(x % 256);
      1:       return 8'((x + y) % 256);
      2:       return 8'(base % 256);
      default: return ((x / 4 + y / 4) % 2 == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic push_frame(input int m);
    int base;
    slot_t s;
    base = mcnt;
    for (int i = 0; i < VB * (W + HB); i++) begin
      s = '{vs: 1'b1, hs: 1'b0, d: 8'h00};
      exp_q.push_back(s);
    end
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        s = '{vs: 1'b0, hs: 1'b1, d: ref_pix(m, x, y, base)};
        exp_q.push_back(s);
      end
      for (int i = 0; i < HB; i++) begin
        s = '{vs: 1'b0, hs: 1'b0, d: 8'h00};
        exp_q.push_back(s);
      end
    end
    mcnt = (mcnt + 1) % 65536;
    done_q.push_back(16'(mcnt));
  endtask

  // Monitor: one slot per pclk rising edge while a frame is in progress
  initial pclk_prev = 1'b0;
  always @(negedge clk) begin
    slot_t e;
    if (cam_pclk_o && !pclk_prev && busy_o) begin
      if (exp_q.size() == 0) begin
        chk("slot_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("slot", 32'({cam_vsync_o, cam_hsync_o, cam_data_o}), 32'(e));
      end
    end
    if (frame_done_o) begin
      if (done_q.size() == 0) chk("done_underflow", 32'(done_q.size()), 32'd1);
      else chk("frame_cnt_at_done", 32'(frame_cnt_o), 32'(done_q.pop_front()));
    end
    pclk_prev = cam_pclk_o;
  end

  task automatic wait_vsync();
    int n;
    n = 0;
    while (!cam_vsync_o && n < PD + 1) begin
      @(negedge clk);
      n++;
    end
    chk("start_latency", 32'(cam_vsync_o), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!frame_done_o && n < FRAME_CYC + PD) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", 32'(frame_done_o), 32'd1);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 32'({cam_pclk_o, cam_vsync_o, cam_hsync_o, cam_data_o, busy_o, frame_done_o}), 32'd0);
    chk({name, "_cnt"}, 32'(frame_cnt_o), 32'd0);
  endtask

  // PCLK_DIV=4 instance: pclk shape and back-to-back frame period
  initial begin
    int n, t0;
    fin4 = 1'b0;
    rst4 = 1'b1;
    en4 = 1'b0;
    mode4 = 2'd0;
    repeat (2) @(negedge clk);
    rst4 = 1'b0;
    en4 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("pclk_div4", 32'(pclk4), ((k % 4) >= 2) ? 32'd1 : 32'd0);
    end
    n = 0;
    while (!done4 && n < 2 * FRAME_CYC + 8) begin @(negedge clk); n++; end
    chk("div4_first_done", 32'(done4), 32'd1);
    t0 = cyc;
    @(negedge clk);
    n = 0;
    while (!done4 && n < 2 * FRAME_CYC + 8) begin @(negedge clk); n++; end
    chk("div4_period", 32'(cyc - t0), 32'(2 * FRAME_CYC));
    chk("div4_frame_cnt", 32'(fcnt4), 32'd2);
    fin4 = 1'b1;
  end

  initial begin
    logic [1:0] seq [5];
    int cur, nxt, t, prev_t, n;
    bit cont, have_prev;
    seq = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
    checks = 0;
    errors = 0;
    mcnt = 0;
    rst_i = 1'b1;
    en_i = 1'b0;
    mode_i = 2'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    rst_i = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      chk("idle_pclk", 32'(cam_pclk_o), ((k % PD) >= PD / 2) ? 32'd1 : 32'd0);
      chk("idle_quiet", 32'({cam_vsync_o, cam_hsync_o, cam_data_o, busy_o, frame_done_o}), 32'd0);
    end

    // Single frame, mode 0, en pulsed for one slot
    mode_i = 2'd0;
    en_i = 1'b1;
    wait_vsync();
    push_frame(0);
    en_i = 1'b0;
    wait_done();
    chk("single_frame_cnt", 32'(frame_cnt_o), 32'd1);
    chk("single_back_idle", 32'(busy_o), 32'd0);
    repeat (20) @(negedge clk);
    chk("single_stays_idle", 32'({busy_o, cam_vsync_o}), 32'd0);

    // Mixed frames: fixed modes first (incl. three back-to-back mode-2), then random
    cur = seq[0];
    mode_i = 2'(cur);
    en_i = 1'b1;
    wait_vsync();
    have_prev = 1'b0;
    prev_t = 0;
    for (int f = 0; f < NF; f++) begin
      push_frame(cur);
      cont = (f >= 1 && f <= 3) ? 1'b1 : (f == NF - 1) ? 1'b0 : 1'($urandom % 2);
      nxt  = (f + 1 < 5) ? int'(seq[f + 1]) : int'($urandom % 4);
      repeat (LINE2_CYC) @(negedge clk);
      chk("hsync_in_line2", 32'(cam_hsync_o), 32'd1);
      en_i = cont;
      mode_i = 2'($urandom % 4);
      repeat (FRAME_CYC * 3 / 4 - LINE2_CYC) @(negedge clk);
      mode_i = 2'(nxt);
      wait_done();
      t = cyc;
      if (have_prev) chk("frame_period", 32'(t - prev_t), 32'(FRAME_CYC));
      if (cont) begin
        chk("no_gap_vsync", 32'(cam_vsync_o), 32'd1);
        prev_t = t;
        have_prev = 1'b1;
      end else begin
        chk("idle_after_frame", 32'(busy_o), 32'd0);
        have_prev = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        chk("idle_no_restart", 32'(cam_vsync_o), 32'd0);
        if (f < NF - 1) begin
          en_i = 1'b1;
          wait_vsync();
        end
      end
      cur = nxt;
    end
    en_i = 1'b0;
    chk("cnt_after_mixed", 32'(frame_cnt_o), 32'(mcnt));

    // Reset in the middle of a line, then a clean frame
    mode_i = 2'($urandom % 4);
    en_i = 1'b1;
    wait_vsync();
    push_frame(int'(mode_i));
    en_i = 1'b0;
    repeat (LINE2_CYC) @(negedge clk);
    chk("hsync_before_rst", 32'(cam_hsync_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_line_reset");
    rst_i = 1'b0;
    exp_q.delete();
    done_q.delete();
    mcnt = 0;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", 32'({busy_o, frame_done_o, frame_cnt_o}), 32'd0);
    mode_i = 2'd1;
    en_i = 1'b1;
    wait_vsync();
    push_frame(1);
    en_i = 1'b0;
    wait_done();
    chk("post_rst_frame_cnt", 32'(frame_cnt_o), 32'd1);
    repeat (4) @(negedge clk);

    chk("slot_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_queue_empty", 32'(done_q.size()), 32'd0);
    n = 0;
    while (!fin4 && n < 4 * FRAME_CYC) begin @(negedge clk); n++; end
    chk("div4_finished", 32'(fin4), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
